lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 44 ++++
 rtl/sync_2ff.sv | 21 ++
 rtl/lcd_timing_gen.sv | 126 ++++++++++++
 tb/tb_lcd_timing_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing defaults, total derivation, FSM encoding and output bundle.
// Also used by the pattern generator so both agree on panel geometry.
package lcd_timing_pkg;

    localparam int H_SYNC_DEF   = 4;
    localparam int H_BP_DEF     = 43;
    localparam int H_ACTIVE_DEF = 480;
    localparam int H_FP_DEF     = 8;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 12;
    localparam int V_ACTIVE_DEF = 272;
    localparam int V_FP_DEF     = 8;

    function automatic int timing_total(input int sync, input int bp,
                                        input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_SYNC_DEF, H_BP_DEF, H_ACTIVE_DEF, H_FP_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_SYNC_DEF, V_BP_DEF, V_ACTIVE_DEF, V_FP_DEF);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } lcd_state_t;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic       frame_start;
        logic [9:0] pix_x;
        logic [8:0] pix_y;
    } lcd_out_t;

    function automatic lcd_out_t idle_out(input logic sync_pol);
        lcd_out_t o;
        o             = '0;
        o.hsync       = ~sync_pol;
        o.vsync       = ~sync_pol;
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: h/v counters gated by synchronized PLL lock,
// all outputs registered one cycle behind the counters they decode.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start
);

    localparam int H_TOTAL = timing_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = timing_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_LO   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

    lcd_state_t    state;
    logic          lock_s;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_wrap, h_act, v_act;
    lcd_out_t      dec, out_q;

    // No reset synchronizer here: lock_s stays 0 for two edges after release,
    // which keeps everything downstream idle until a clean clocked start.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + HW'(1);
        v_nxt  = v_cnt;
        if (h_wrap)
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end

    always_comb begin
        h_act           = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_LAST);
        v_act           = (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_LAST);
        dec             = idle_out(SYNC_POL);
        dec.hsync       = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        dec.vsync       = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        dec.de          = h_act && v_act;
        dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
        if (h_act && v_act) begin
            dec.pix_x = 10'(h_cnt - H_ACT_LO);
            dec.pix_y = 9'(v_cnt - V_ACT_LO);
        end
    end

    // Leaving WAIT_LOCK already decodes (0,0), so frame_start lands on the
    // first edge that sees lock_s high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_LOCK;
            h_cnt <= '0;
            v_cnt <= '0;
            out_q <= idle_out(SYNC_POL);
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= RUN;
                        h_cnt <= h_nxt;
                        v_cnt <= v_nxt;
                        out_q <= dec;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        h_cnt <= '0;
                        v_cnt <= '0;
                        out_q <= idle_out(SYNC_POL);
                    end else begin
                        h_cnt <= h_nxt;
                        v_cnt <= v_nxt;
                        out_q <= dec;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    h_cnt <= '0;
                    v_cnt <= '0;
                    out_q <= idle_out(SYNC_POL);
                end
            endcase
        end
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign de          = out_q.de;
    assign frame_start = out_q.frame_start;
    assign pix_x       = out_q.pix_x;
    assign pix_y       = out_q.pix_y;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: two small-geometry instances (active-low and
// active-high sync) checked every cycle against a raster-position model.
module tb_lcd_timing_gen;

    localparam int HS = 2, HB = 3, HA = 6, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic       clk = 1'b0, reset = 1'b1, pll_lock = 1'b0;
    logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic [31:0] obs_a, obs_b;

    assign obs_a = {9'd0, hs_a, vs_a, de_a, fs_a, x_a, y_a};
    assign obs_b = {9'd0, hs_b, vs_b, de_b, fs_b, x_b, y_b};

    lcd_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
                     .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
                     .SYNC_POL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(hs_a), .vsync(vs_a),
        .de(de_a), .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a));

    lcd_timing_gen #(.H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
                     .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
                     .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(hs_b), .vsync(vs_b),
        .de(de_b), .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b));

    always #5 clk = ~clk;

    int pass_n = 0, fail_n = 0, total_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: lock is seen two edges late; while seen, output reflects the
    // raster position = edges since lock was first seen, modulo frame length.
    logic lk1 = 1'b0, lk2 = 1'b0;
    bit   act = 1'b0;
    int   run = 0, pos = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lk1 <= 1'b0;
            lk2 <= 1'b0;
            act <= 1'b0;
            run <= 0;
            pos <= 0;
        end else begin
            lk1 <= pll_lock;
            lk2 <= lk1;
            act <= lk2;
            if (lk2) begin
                pos <= run;
                run <= run + 1;
            end else begin
                run <= 0;
            end
        end
    end

    function automatic logic [31:0] expect_out(input bit pol, input bit on, input int p);
        int x, y;
        bit hs, vs, d, fs;
        logic [9:0] px;
        logic [8:0] py;
        hs = !pol; vs = !pol; d = 1'b0; fs = 1'b0; px = '0; py = '0;
        if (on) begin
            p  = p % FT;
            x  = p % HT;
            y  = p / HT;
            if (x < HS) hs = pol;
            if (y < VS) vs = pol;
            fs = (p == 0);
            d  = (x >= HS + HB) && (x < HS + HB + HA) && (y >= VS + VB) && (y < VS + VB + VA);
            if (d) begin
                px = 10'(x - HS - HB);
                py = 9'(y - VS - VB);
            end
        end
        return {9'd0, hs, vs, d, fs, px, py};
    endfunction

    int cyc, n_de, n_hs, n_hs_b, n_vs, n_fs, fs_cyc, first_de;
    logic [9:0] fx, lx;
    logic [8:0] fy, ly;

    task automatic clear_stats();
        cyc = 0; n_de = 0; n_hs = 0; n_hs_b = 0; n_vs = 0; n_fs = 0;
        fs_cyc = -1; first_de = -1; fx = '1; fy = '1; lx = '1; ly = '1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            check("out_a", obs_a, expect_out(1'b0, act, pos));
            check("out_b", obs_b, expect_out(1'b1, act, pos));
            if (fs_a) begin n_fs++; fs_cyc = cyc; end
            if (!hs_a) n_hs++;
            if (hs_b)  n_hs_b++;
            if (!vs_a) n_vs++;
            if (de_a) begin
                n_de++;
                if (first_de < 0) begin first_de = cyc; fx = x_a; fy = y_a; end
                lx = x_a; ly = y_a;
            end
        end
    endtask

    task automatic wait_fs(output int n, input int limit);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!fs_a && n < limit);
    endtask

    task automatic frame_checks(input string tag);
        clear_stats();
        tick(FT);
        check({tag, "_period"}, fs_cyc, FT);
        check({tag, "_fs_count"}, n_fs, 1);
        check({tag, "_hs_cycles"}, n_hs, HS * VT);
        check({tag, "_hs_hi_pol1"}, n_hs_b, HS * VT);
        check({tag, "_vs_cycles"}, n_vs, VS * HT);
        check({tag, "_de_cycles"}, n_de, HA * VA);
        check({tag, "_first_de"}, first_de, (VS + VB) * HT + HS + HB);
        check({tag, "_first_pix"}, {fx, fy}, 19'd0);
        check({tag, "_last_pix"}, {lx, ly}, {10'(HA - 1), 9'(VA - 1)});
    endtask

    initial begin
        int n;
        pll_lock = 1'b1;
        #12;
        check("rst_idle_a", obs_a, {9'd0, 4'b1100, 19'd0});
        check("rst_idle_b", obs_b, {9'd0, 4'b0000, 19'd0});
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        wait_fs(n, 20);
        check("lock_to_fs", n, 3);
        frame_checks("frame0");
        frame_checks("frame1");

        for (int k = 0; k < 4; k++) begin
            tick($urandom_range(20, 300));
            pll_lock = 1'b0;
            tick(3);
            check("drop_idle_a", obs_a, {9'd0, 4'b1100, 19'd0});
            check("drop_idle_b", obs_b, {9'd0, 4'b0000, 19'd0});
            tick($urandom_range(0, 10));
            pll_lock = 1'b1;
            wait_fs(n, 20);
            check("relock_fs", n, 3);
        end
        frame_checks("relock");

        n = 0;
        while (!de_a && n < FT) begin
            tick(1);
            n++;
        end
        check("found_de", de_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_a", obs_a, {9'd0, 4'b1100, 19'd0});
        check("async_rst_b", obs_b, {9'd0, 4'b0000, 19'd0});
        @(negedge clk);
        reset = 1'b0;
        wait_fs(n, 20);
        check("post_rst_fs", n, 3);
        tick(40);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
